// File: rtl/fp_simd_issuer.sv
`default_nettype none
// ============================================================================
// Module   : fp_simd_issuer
// Purpose  : Queues FP SIMD commands, issues them one at a time to a SIMD
//            unit and returns each result through a response handshake.
//            Optional WAIT timeout enabled by FP_SIMD_ISSUER_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fp_simd_issuer #(
  parameter int FIFO_DEPTH = 2,
  parameter int TIMEOUT    = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic [2:0]  i_cmd_op,
  input  logic [87:0] i_cmd_a,
  input  logic [87:0] i_cmd_b,
  output logic        o_simd_en,
  output logic [2:0]  o_simd_opcode,
  output logic [87:0] o_simd_in1,
  output logic [87:0] o_simd_in2,
  input  logic        i_simd_busy,
  input  logic        i_simd_valid,
  input  logic [87:0] i_simd_output,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [87:0] o_rsp_data,
  output logic [2:0]  o_rsp_op,
  output logic        o_err
);

  localparam int c_aw = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int c_ew = 3 + 88 + 88;

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_issue = 2'd1;
  localparam logic [1:0] c_st_wait  = 2'd2;
  localparam logic [1:0] c_st_resp  = 2'd3;

  logic [c_ew-1:0] r_mem [FIFO_DEPTH];
  logic [c_aw:0]   r_wr_ptr;
  logic [c_aw:0]   r_rd_ptr;
  logic            r_rst_done;
  logic [1:0]      r_state;
  logic [2:0]      r_simd_opcode;
  logic [87:0]     r_simd_in1;
  logic [87:0]     r_simd_in2;
  logic [87:0]     r_rsp_data;
  logic [2:0]      r_rsp_op;

  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic            w_timeout;
  logic [c_ew-1:0] w_head;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                   (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
  assign w_push  = i_cmd_valid && o_cmd_ready;
  assign w_head  = r_mem[r_rd_ptr[c_aw-1:0]];

  assign w_pop = ((r_state == c_st_issue) && (r_simd_opcode[2:1] == 2'b11)) ||
                 ((r_state == c_st_wait) && (i_simd_valid || w_timeout));

  assign o_cmd_ready   = r_rst_done && !w_full;
  assign o_simd_en     = (r_state == c_st_issue);
  assign o_simd_opcode = r_simd_opcode;
  assign o_simd_in1    = r_simd_in1;
  assign o_simd_in2    = r_simd_in2;
  assign o_rsp_valid   = (r_state == c_st_resp);
  assign o_rsp_data    = r_rsp_data;
  assign o_rsp_op      = r_rsp_op;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[c_aw-1:0]] <= {i_cmd_op, i_cmd_a, i_cmd_b};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_rst_done <= 1'b0;
    end else begin
      r_rst_done <= 1'b1;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= c_st_idle;
      r_simd_opcode <= '0;
      r_simd_in1    <= '0;
      r_simd_in2    <= '0;
      r_rsp_data    <= '0;
      r_rsp_op      <= '0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (!w_empty && !i_simd_busy) begin
            r_state       <= c_st_issue;
            r_simd_opcode <= w_head[c_ew-1 -: 3];
            r_simd_in1    <= w_head[175:88];
            r_simd_in2    <= w_head[87:0];
          end
        end
        c_st_issue: begin
          // Loads produce no result, so they retire straight from ISSUE.
          r_state <= (r_simd_opcode[2:1] == 2'b11) ? c_st_idle : c_st_wait;
        end
        c_st_wait: begin
          if (i_simd_valid) begin
            r_rsp_data <= i_simd_output;
            r_rsp_op   <= r_simd_opcode;
            r_state    <= c_st_resp;
          end else if (w_timeout) begin
            r_rsp_data <= '0;
            r_rsp_op   <= r_simd_opcode;
            r_state    <= c_st_resp;
          end
        end
        c_st_resp: begin
          if (i_rsp_ready) begin
            r_state <= c_st_idle;
          end
        end
        default: r_state <= c_st_idle;
      endcase
    end
  end

`ifdef FP_SIMD_ISSUER_TIMEOUT_EN
  localparam int c_cw = $clog2(TIMEOUT + 1);

  logic [c_cw-1:0] r_tmo_cnt;
  logic            r_err;

  // Fires on the TIMEOUT-th WAIT cycle without a result.
  assign w_timeout = (r_state == c_st_wait) && !i_simd_valid &&
                     (r_tmo_cnt == c_cw'(TIMEOUT - 1));
  assign o_err     = r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo_cnt <= '0;
      r_err     <= 1'b0;
    end else begin
      if (r_state == c_st_issue) begin
        r_tmo_cnt <= '0;
      end else if ((r_state == c_st_wait) && !w_timeout) begin
        r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end
      if (w_timeout) begin
        r_err <= 1'b1;
      end
    end
  end
`else
  assign w_timeout = 1'b0;
  assign o_err     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fp_simd_issuer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_simd_issuer
// Purpose  : Directed self-checking bench for fp_simd_issuer with a 4-cycle
//            SIMD unit model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp_simd_issuer;

  localparam logic [21:0] c_one   = 22'h0FE000;
  localparam logic [21:0] c_two   = 22'h100000;
  localparam logic [21:0] c_three = 22'h101000;

  localparam logic [87:0] c_a1 = {22'h000001, 22'h000002, 22'h000003, 22'h000004};
  localparam logic [87:0] c_b1 = {4{22'h3FFFFF}};
  localparam logic [87:0] c_x1 = {22'h3FFFFE, 22'h3FFFFD, 22'h3FFFFC, 22'h3FFFFB};
  localparam logic [87:0] c_a2 = {4{22'h155555}};
  localparam logic [87:0] c_b2 = {4{22'h2AAAAA}};
  localparam logic [87:0] c_x2 = {4{22'h3FFFFF}};
  localparam logic [87:0] c_xm = {4{22'h1FE000}};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_cmd_valid = 1'b0;
  logic        o_cmd_ready;
  logic [2:0]  i_cmd_op = '0;
  logic [87:0] i_cmd_a = '0;
  logic [87:0] i_cmd_b = '0;
  logic        o_simd_en;
  logic [2:0]  o_simd_opcode;
  logic [87:0] o_simd_in1;
  logic [87:0] o_simd_in2;
  logic        i_simd_busy = 1'b0;
  logic        i_simd_valid;
  logic [87:0] i_simd_output;
  logic        o_rsp_valid;
  logic        i_rsp_ready = 1'b0;
  logic [87:0] o_rsp_data;
  logic [2:0]  o_rsp_op;
  logic        o_err;

  logic        r_model_valid = 1'b0;
  logic [87:0] r_model_out = '0;
  logic [2:0]  r_model_cnt = '0;
  logic        model_en = 1'b1;
  logic        model_xor = 1'b1;
  logic [87:0] model_data = '0;
  logic        stray_valid = 1'b0;

  int checks = 0;
  int errors = 0;
  int en_cnt = 0;
  int rsp_cnt = 0;

  assign i_simd_valid  = r_model_valid | stray_valid;
  assign i_simd_output = r_model_out;

  fp_simd_issuer #(.FIFO_DEPTH(2), .TIMEOUT(15)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_cmd_valid   (i_cmd_valid),
    .o_cmd_ready   (o_cmd_ready),
    .i_cmd_op      (i_cmd_op),
    .i_cmd_a       (i_cmd_a),
    .i_cmd_b       (i_cmd_b),
    .o_simd_en     (o_simd_en),
    .o_simd_opcode (o_simd_opcode),
    .o_simd_in1    (o_simd_in1),
    .o_simd_in2    (o_simd_in2),
    .i_simd_busy   (i_simd_busy),
    .i_simd_valid  (i_simd_valid),
    .i_simd_output (i_simd_output),
    .o_rsp_valid   (o_rsp_valid),
    .i_rsp_ready   (i_rsp_ready),
    .o_rsp_data    (o_rsp_data),
    .o_rsp_op      (o_rsp_op),
    .o_err         (o_err)
  );

  always #5 clk = ~clk;

  // SIMD unit model: result valid for one cycle, 4 cycles after the enable.
  always @(posedge clk) begin
    if (!rst_n) begin
      r_model_cnt   <= '0;
      r_model_valid <= 1'b0;
    end else begin
      if (o_simd_en && model_en && (o_simd_opcode[2:1] != 2'b11)) begin
        r_model_cnt <= 3'd3;
      end else if (r_model_cnt != 0) begin
        r_model_cnt <= r_model_cnt - 3'd1;
      end
      r_model_valid <= (r_model_cnt == 3'd1);
      if (r_model_cnt == 3'd1) begin
        r_model_out <= model_xor ? (o_simd_in1 ^ o_simd_in2) : model_data;
      end
    end
  end

  always @(posedge clk) begin
    if (o_simd_en) en_cnt <= en_cnt + 1;
    if (o_rsp_valid && i_rsp_ready) rsp_cnt <= rsp_cnt + 1;
  end

  task automatic push(input logic [2:0] op, input logic [87:0] a, input logic [87:0] b);
    bit ok = 0;
    i_cmd_valid = 1'b1;
    i_cmd_op    = op;
    i_cmd_a     = a;
    i_cmd_b     = b;
    for (int i = 0; i < 50; i++) begin
      if (o_cmd_ready) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL push_accept: o_cmd_ready got 0 required 1 (op %b)", op);
    end
    @(negedge clk);
    i_cmd_valid = 1'b0;
  endtask

  task automatic wait_en(input string name);
    bit ok = 0;
    for (int i = 0; i < 60; i++) begin
      if (o_simd_en) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: o_simd_en got 0 required 1 within bound", name);
    end
  endtask

  task automatic pop_rsp(input logic [87:0] exp_data, input logic [2:0] exp_op, input string name);
    bit ok = 0;
    for (int i = 0; i < 60; i++) begin
      if (o_rsp_valid) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!ok || o_rsp_data !== exp_data || o_rsp_op !== exp_op) begin
      errors++;
      $display("FAIL %s: valid %b data %h op %b required valid 1 data %h op %b",
               name, o_rsp_valid, o_rsp_data, o_rsp_op, exp_data, exp_op);
    end
    i_rsp_ready = 1'b1;
    @(negedge clk);
    i_rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({o_simd_en, o_simd_opcode, o_simd_in1, o_simd_in2} !== '0) begin
      errors++;
      $display("FAIL reset_simd: en %b op %b in1 %h in2 %h required all 0",
               o_simd_en, o_simd_opcode, o_simd_in1, o_simd_in2);
    end
    checks++;
    if ({o_rsp_valid, o_rsp_data, o_rsp_op, o_err, o_cmd_ready} !== '0) begin
      errors++;
      $display("FAIL reset_rsp: valid %b data %h op %b err %b ready %b required all 0",
               o_rsp_valid, o_rsp_data, o_rsp_op, o_err, o_cmd_ready);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (o_cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready_rise: o_cmd_ready got %b required 1", o_cmd_ready);
    end
  endtask

  task automatic test_add_latency;
    int en0 = en_cnt;
    model_xor  = 1'b0;
    model_data = {4{c_three}};
    push(3'b000, {4{c_one}}, {4{c_two}});
    wait_en("add_issue");
    checks++;
    if (o_simd_opcode !== 3'b000 || o_simd_in1 !== {4{c_one}} || o_simd_in2 !== {4{c_two}}) begin
      errors++;
      $display("FAIL add_operands: op %b in1 %h in2 %h", o_simd_opcode, o_simd_in1, o_simd_in2);
    end
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) begin
        checks++;
        if (o_simd_en !== 1'b0) begin
          errors++;
          $display("FAIL add_en_single: o_simd_en got %b required 0", o_simd_en);
        end
      end
      if (k == 4) begin
        checks++;
        if (o_rsp_valid !== 1'b0) begin
          errors++;
          $display("FAIL add_early_rsp: o_rsp_valid got %b required 0", o_rsp_valid);
        end
      end
    end
    checks++;
    if (o_rsp_valid !== 1'b1 || o_rsp_data !== {4{c_three}} || o_rsp_op !== 3'b000) begin
      errors++;
      $display("FAIL add_rsp_at_5: valid %b data %h op %b required 1 %h 000",
               o_rsp_valid, o_rsp_data, o_rsp_op, {4{c_three}});
    end
    i_rsp_ready = 1'b1;
    @(negedge clk);
    i_rsp_ready = 1'b0;
    checks++;
    if (o_rsp_valid !== 1'b0 || en_cnt - en0 != 1) begin
      errors++;
      $display("FAIL add_complete: valid %b en pulses %0d required 0 and 1", o_rsp_valid, en_cnt - en0);
    end
    model_xor = 1'b1;
  endtask

  task automatic test_load_then_mul;
    int en0 = en_cnt;
    int rsp0 = rsp_cnt;
    bit ok = 0;
    push(3'b110, c_a2, c_b2);
    push(3'b010, {4{c_one}}, {4{c_two}});
    for (int i = 0; i < 40; i++) begin
      if (o_simd_en && o_simd_opcode == 3'b010) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL mul_issue: opcode %b en %b required 010 issue", o_simd_opcode, o_simd_en);
    end
    for (int i = 0; i < 20 && !o_rsp_valid; i++) begin
      checks++;
      if (o_simd_opcode !== 3'b010 || o_simd_in1 !== {4{c_one}}) begin
        errors++;
        $display("FAIL mul_hold: opcode %b in1 %h required 010 %h", o_simd_opcode, o_simd_in1, {4{c_one}});
      end
      @(negedge clk);
    end
    pop_rsp(c_xm, 3'b010, "mul_rsp");
    repeat (4) @(negedge clk);
    checks++;
    if (en_cnt - en0 != 2 || rsp_cnt - rsp0 != 1) begin
      errors++;
      $display("FAIL load_mul_counts: en %0d rsp %0d required 2 and 1", en_cnt - en0, rsp_cnt - rsp0);
    end
  endtask

  task automatic test_back_to_back;
    int en0 = en_cnt;
    push(3'b000, c_a1, c_b1);
    push(3'b001, c_a2, c_b2);
    checks++;
    if (o_cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL fifo_full_ready: o_cmd_ready got %b required 0", o_cmd_ready);
    end
    for (int i = 0; i < 20 && !o_rsp_valid; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    checks++;
    if (o_rsp_valid !== 1'b1 || o_rsp_data !== c_x1 || en_cnt - en0 != 1 || o_cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_hold: valid %b data %h en %0d ready %b required 1 %h 1 1",
               o_rsp_valid, o_rsp_data, en_cnt - en0, o_cmd_ready, c_x1);
    end
    pop_rsp(c_x1, 3'b000, "b2b_first");
    pop_rsp(c_x2, 3'b001, "b2b_second");
  endtask

  task automatic test_busy;
    int en0 = en_cnt;
    i_simd_busy = 1'b1;
    push(3'b010, c_a1, c_b1);
    repeat (10) @(negedge clk);
    checks++;
    if (en_cnt != en0 || o_simd_en !== 1'b0) begin
      errors++;
      $display("FAIL busy_block: en pulses %0d required 0", en_cnt - en0);
    end
    i_simd_busy = 1'b0;
    wait_en("busy_release");
    pop_rsp(c_x1, 3'b010, "busy_rsp");
  endtask

  task automatic test_stray_valid;
    int rsp0 = rsp_cnt;
    stray_valid = 1'b1;
    @(negedge clk);
    stray_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (o_rsp_valid !== 1'b0 || rsp_cnt != rsp0) begin
      errors++;
      $display("FAIL stray_valid: o_rsp_valid got %b required 0", o_rsp_valid);
    end
  endtask

  task automatic test_reset_in_wait;
    int en0;
    model_en = 1'b0;
    push(3'b000, c_a1, c_b1);
    wait_en("rst_issue");
    push(3'b001, c_a2, c_b2);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({o_simd_en, o_simd_opcode, o_simd_in1, o_simd_in2, o_rsp_valid, o_rsp_data,
         o_rsp_op, o_err, o_cmd_ready} !== '0) begin
      errors++;
      $display("FAIL rst_wait_outputs: en %b op %b in1 %h rsp %b data %h ready %b required all 0",
               o_simd_en, o_simd_opcode, o_simd_in1, o_rsp_valid, o_rsp_data, o_cmd_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_en = 1'b1;
    en0 = en_cnt;
    repeat (12) @(negedge clk);
    checks++;
    if (o_rsp_valid !== 1'b0 || en_cnt != en0 || o_cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_wait_after: rsp %b en %0d ready %b required 0 0 1",
               o_rsp_valid, en_cnt - en0, o_cmd_ready);
    end
  endtask

  task automatic test_timeout;
    model_en = 1'b0;
    push(3'b001, c_a1, c_b1);
    wait_en("tmo_issue");
`ifdef FP_SIMD_ISSUER_TIMEOUT_EN
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 15) begin
        checks++;
        if (o_rsp_valid !== 1'b0 || o_err !== 1'b0) begin
          errors++;
          $display("FAIL tmo_early: rsp %b err %b required 0 0", o_rsp_valid, o_err);
        end
      end
    end
    checks++;
    if (o_rsp_valid !== 1'b1 || o_err !== 1'b1 || o_rsp_data !== '0) begin
      errors++;
      $display("FAIL tmo_fire: rsp %b err %b data %h required 1 1 0", o_rsp_valid, o_err, o_rsp_data);
    end
    pop_rsp('0, 3'b001, "tmo_rsp");
    repeat (3) @(negedge clk);
    checks++;
    if (o_err !== 1'b1) begin
      errors++;
      $display("FAIL tmo_sticky: o_err got %b required 1", o_err);
    end
`else
    repeat (40) @(negedge clk);
    checks++;
    if (o_rsp_valid !== 1'b0 || o_err !== 1'b0 || o_cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL no_tmo_wait: rsp %b err %b ready %b required 0 0 1", o_rsp_valid, o_err, o_cmd_ready);
    end
`endif
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (o_err !== 1'b0) begin
      errors++;
      $display("FAIL err_clear: o_err got %b required 0", o_err);
    end
    rst_n = 1'b1;
    model_en = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_add_latency();
    test_load_then_mul();
    test_back_to_back();
    test_busy();
    test_stray_valid();
    test_reset_in_wait();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/fp_simd_issuer.md
FP_SIMD_ISSUER -- requirements
Module: fp_simd_issuer

Interface
REQ-001 Parameter FIFO_DEPTH, default 2, command FIFO entries; power of two, at least 2.
REQ-002 Parameter TIMEOUT, default 15, maximum cycles in WAIT before abort; must be at least 12.
REQ-003 clk  in  1  single clock; all logic on posedge.
REQ-004 rst_n  in  1  reset; asynchronous, active-low.
REQ-005 i_cmd_valid / o_cmd_ready  in/out  1/1  command handshake.
REQ-006 i_cmd_op  in  3  FP_SIMD opcode (000 add, 001 sub, 010 mul, 011 rcp, 100 reduce_add, 101 reduce_mul, 110 load1, 111 load2).
REQ-007 i_cmd_a, i_cmd_b  in  88  operands: 4 lanes of 22-bit float, lane 0 in bits [87:66].
REQ-008 o_simd_en, o_simd_opcode, o_simd_in1, o_simd_in2  out  1/3/88/88  drive the SIMD unit.
REQ-009 i_simd_busy, i_simd_valid, i_simd_output  in  1/1/88  SIMD unit status and result.
REQ-010 o_rsp_valid / i_rsp_ready  out/in  1/1  response handshake.
REQ-011 o_rsp_data, o_rsp_op  out  88/3  captured result and its opcode.
REQ-012 o_err  out  1  sticky timeout flag.

Function
REQ-013 o_cmd_ready = FIFO not full; a push occurs when i_cmd_valid and o_cmd_ready are both high.
REQ-014 The FIFO stores {op, a, b}; a push to a full FIFO is impossible by construction; a push and a pop in the same cycle are both honoured; wrap-around uses pointers with one extra bit.
REQ-015 FSM states are IDLE, ISSUE, WAIT and RESP.
REQ-016 IDLE: FIFO non-empty and i_simd_busy low -> ISSUE; otherwise remain in IDLE.
REQ-017 On the IDLE->ISSUE edge, o_simd_opcode, o_simd_in1 and o_simd_in2 are registered from the FIFO head.
REQ-018 ISSUE: o_simd_en = 1 for exactly one cycle.
REQ-019 In ISSUE, op 11x (load1/load2) pops the FIFO and goes to IDLE with no response; any other op goes to WAIT.
REQ-020 o_simd_opcode and operands are held stable from ISSUE until the FSM leaves WAIT, because the SIMD unit samples the opcode in every pipeline stage.
REQ-021 WAIT: o_simd_en = 0; on i_simd_valid, capture i_simd_output into o_rsp_data and the op into o_rsp_op, pop the FIFO, and go to RESP.
REQ-022 RESP: o_rsp_valid = 1, with o_rsp_data and o_rsp_op stable; on i_rsp_ready go to IDLE.
REQ-023 Issue-to-response latency equals the SIMD latency plus 1 cycle, with the first response visible at ISSUE+latency+1.
REQ-024 i_simd_valid outside WAIT is ignored.
REQ-025 Back-to-back throughput: the next ISSUE occurs no earlier than the cycle after RESP completes.

Reset
REQ-026 While rst_n is low, all of the following are 0: o_simd_en, o_simd_opcode, o_simd_in1, o_simd_in2, o_rsp_valid, o_rsp_data, o_rsp_op, o_err, the FIFO pointers and the timeout counter.
REQ-027 While rst_n is low, the FSM is in IDLE and o_cmd_ready is 0; o_cmd_ready rises in the first cycle after deassertion.
REQ-028 Reset asserted mid-operation discards the in-flight command and all queued commands, with no response produced.

Configuration
REQ-029 Macro FP_SIMD_ISSUER_TIMEOUT_EN.
REQ-030 Defined: a counter cleared on ISSUE and incremented each WAIT cycle.
REQ-031 Defined: if the counter reaches TIMEOUT with i_simd_valid low, set o_err, pop the FIFO, drive o_rsp_data = 0, and go to RESP.
REQ-032 Defined: o_err clears only on reset.
REQ-033 Undefined: no counter; WAIT persists until i_simd_valid; o_err is tied to 0.

Verification
REQ-034 Push add with a = 4x1.0, b = 4x2.0; SIMD model returns 4x3.0 after 4 cycles -> one o_simd_en pulse; o_rsp_data = 4x3.0 and o_rsp_op = 000 at ISSUE+5.
REQ-035 Push load1 then mul -> load1 produces no response; mul issues next with opcode 010 held stable through WAIT; exactly one response.
REQ-036 Fill the FIFO (2 commands) with i_rsp_ready = 0 -> o_cmd_ready = 0; the second command waits; raising ready drains 2 responses in order.
REQ-037 Hold i_simd_busy = 1 with the FIFO non-empty -> no o_simd_en pulse until busy drops.
REQ-038 With FP_SIMD_ISSUER_TIMEOUT_EN defined, never assert i_simd_valid -> o_err = 1 and o_rsp_valid = 1 with data 0 after 15 WAIT cycles; without the macro, the FSM stays in WAIT.
REQ-039 Assert rst_n low during WAIT with 1 command queued -> all outputs 0; after release, no response appears and o_cmd_ready = 1.
